// File: rtl/swd_host.sv
// Serial Wire Debug host: turns request/response handshakes into SWD line
// transfers (request, turnaround, ACK, data) and line resets, each followed by idle bits.
module swd_host #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_CYC = 2
) (
    input  logic        fpga_clk,
    input  logic        fpga_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_line_reset,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        swclk,
    output logic        swdio_out,
    output logic        swdio_oe,
    input  logic        swdio_in
);

    typedef enum logic [3:0] {
        IDLE,
        LRST,
        REQ,
        TRN1,
        ACK,
        RDATA,
        TRN2,
        WDATA,
        IDLE_BITS
    } state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
    localparam state_t     AFTER_OP  = (IDLE_CYC == 0) ? IDLE : IDLE_BITS;

    state_t      state;
    logic [8:0]  div_cnt;
    logic [7:0]  bit_cnt;

    logic        op_lrst;
    logic        op_apndp;
    logic        op_rnw;
    logic [1:0]  op_addr;
    logic [31:0] op_wdata;

    logic [2:0]  ack_sh;
    logic [32:0] rdata_sh;

    logic        ack_ok;
    logic        rd_ok;
    logic [7:0]  req_pkt;
    state_t      nxt_state;
    logic [7:0]  nxt_bit;
    logic        nxt_out;
    logic        nxt_oe;

    assign ack_ok = (ack_sh == 3'b001);
    assign rd_ok  = !op_lrst && ack_ok && op_rnw;

    // Request header as sent on the wire, bit 0 first: start, APnDP, RnW, A2, A3, parity, stop, park.
    assign req_pkt = {1'b1, 1'b0, ^{op_apndp, op_rnw, op_addr}, op_addr[1], op_addr[0],
                      op_rnw, op_apndp, 1'b1};

    // Sequencing of the bit periods: which state and bit index the next bit belongs to.
    always_comb begin
        nxt_state = state;
        nxt_bit   = bit_cnt + 8'd1;
        case (state)
            LRST: begin
                if (bit_cnt == 8'd55) begin
                    nxt_state = AFTER_OP;
                    nxt_bit   = 8'd0;
                end
            end
            REQ: begin
                if (bit_cnt == 8'd7) begin
                    nxt_state = TRN1;
                    nxt_bit   = 8'd0;
                end
            end
            TRN1: begin
                nxt_state = ACK;
                nxt_bit   = 8'd0;
            end
            ACK: begin
                if (bit_cnt == 8'd2) begin
                    nxt_state = (ack_ok && op_rnw) ? RDATA : TRN2;
                    nxt_bit   = 8'd0;
                end
            end
            RDATA: begin
                if (bit_cnt == 8'd32) begin
                    nxt_state = TRN2;
                    nxt_bit   = 8'd0;
                end
            end
            TRN2: begin
                nxt_state = (ack_ok && !op_rnw) ? WDATA : AFTER_OP;
                nxt_bit   = 8'd0;
            end
            WDATA: begin
                if (bit_cnt == 8'd32) begin
                    nxt_state = AFTER_OP;
                    nxt_bit   = 8'd0;
                end
            end
            IDLE_BITS: begin
                if (bit_cnt == IDLE_LAST) begin
                    nxt_state = IDLE;
                    nxt_bit   = 8'd0;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_bit   = 8'd0;
            end
        endcase
    end

    // Line drive for the upcoming bit; idle and idle bits hold the line low.
    always_comb begin
        nxt_oe  = 1'b1;
        nxt_out = 1'b0;
        case (nxt_state)
            LRST:                   nxt_out = 1'b1;
            REQ:                    nxt_out = req_pkt[nxt_bit[2:0]];
            TRN1, ACK, RDATA, TRN2: nxt_oe  = 1'b0;
            WDATA:                  nxt_out = (nxt_bit == 8'd32) ? ^op_wdata : op_wdata[nxt_bit[4:0]];
            default:                ;
        endcase
    end

    // Drive changes only at bit starts; the target is sampled just before swclk rises.
    always_ff @(posedge fpga_clk) begin
        if (!fpga_rst) begin
            state     <= IDLE;
            div_cnt   <= 9'd0;
            bit_cnt   <= 8'd0;
            swclk     <= 1'b0;
            swdio_oe  <= 1'b1;
            swdio_out <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_ack   <= 3'b000;
            rsp_rdata <= 32'd0;
            rsp_perr  <= 1'b0;
            op_lrst   <= 1'b0;
            op_apndp  <= 1'b0;
            op_rnw    <= 1'b0;
            op_addr   <= 2'd0;
            op_wdata  <= 32'd0;
            ack_sh    <= 3'b000;
            rdata_sh  <= 33'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == IDLE) begin
                if (req_valid && req_ready) begin
                    state     <= req_line_reset ? LRST : REQ;
                    req_ready <= 1'b0;
                    op_lrst   <= req_line_reset;
                    op_apndp  <= req_apndp;
                    op_rnw    <= req_rnw;
                    op_addr   <= req_addr;
                    op_wdata  <= req_wdata;
                    div_cnt   <= 9'd0;
                    bit_cnt   <= 8'd0;
                    swdio_oe  <= 1'b1;
                    swdio_out <= 1'b1;
                    ack_sh    <= 3'b000;
                    rdata_sh  <= 33'd0;
                end
            end else if (div_cnt == BIT_LAST) begin
                div_cnt   <= 9'd0;
                swclk     <= 1'b0;
                state     <= nxt_state;
                bit_cnt   <= nxt_bit;
                swdio_oe  <= nxt_oe;
                swdio_out <= nxt_out;
                if (nxt_state == IDLE) begin
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b1;
                    rsp_ack   <= op_lrst ? 3'b000 : ack_sh;
                    rsp_rdata <= rd_ok ? rdata_sh[31:0] : 32'd0;
                    rsp_perr  <= rd_ok & (^rdata_sh);
                end
            end else begin
                div_cnt <= div_cnt + 9'd1;
                if (div_cnt == HALF_LAST) begin
                    swclk <= 1'b1;
                    if (state == ACK) begin
                        ack_sh <= {swdio_in, ack_sh[2:1]};
                    end
                    if (state == RDATA) begin
                        rdata_sh <= {swdio_in, rdata_sh[32:1]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_swd_host.sv
// Bench for swd_host: a bit-indexed target model answers on swdio_in, a line monitor
// captures every host-driven bit, and a scoreboard checks each response.
module tb_swd_host;

    localparam int CLK_DIV  = 4;
    localparam int IDLE_CYC = 2;
    localparam int BIT_CYC  = 2 * CLK_DIV;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_line_reset = 1'b0;
    logic        req_apndp = 1'b0;
    logic        req_rnw = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;
    logic        swclk;
    logic        swdio_out;
    logic        swdio_oe;
    logic        swdio_in;

    swd_host #(.CLK_DIV(CLK_DIV), .IDLE_CYC(IDLE_CYC)) dut (
        .fpga_clk      (fpga_clk),
        .fpga_rst      (fpga_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_line_reset(req_line_reset),
        .req_apndp     (req_apndp),
        .req_rnw       (req_rnw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ack       (rsp_ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_perr      (rsp_perr),
        .swclk         (swclk),
        .swdio_out     (swdio_out),
        .swdio_oe      (swdio_oe),
        .swdio_in      (swdio_in)
    );

    always #5 fpga_clk = ~fpga_clk;

    typedef struct {
        int           id;
        int           acc_cyc;
        int           n_bits;
        logic [2:0]   ack;
        logic [31:0]  rdata;
        logic         perr;
        logic [127:0] oe;
        logic [127:0] out;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tgt_bit = 0;
    int drive_glitch = 0;
    int op_id = 0;

    logic         sw_d = 1'b0;
    logic         out_d = 1'b0;
    logic         oe_d = 1'b1;
    logic [127:0] cap_out = '0;
    logic [127:0] cap_oe = '0;
    logic [127:0] reply = '0;
    logic [6:0]   tgt_idx;

    assign tgt_idx  = tgt_bit[6:0];
    assign swdio_in = reply[tgt_idx];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: counts swclk pulses, records the host drive seen during each high phase.
    always @(posedge fpga_clk) begin
        cyc   <= cyc + 1;
        sw_d  <= swclk;
        out_d <= swdio_out;
        oe_d  <= swdio_oe;
        if (req_valid && req_ready && fpga_rst) begin
            tgt_bit <= 0;
        end else if (swclk && !sw_d) begin
            if (tgt_bit < 128) begin
                cap_out[tgt_bit] <= swdio_out;
                cap_oe[tgt_bit]  <= swdio_oe;
            end
            tgt_bit <= tgt_bit + 1;
        end
        if (fpga_rst && swclk && sw_d && ((swdio_out != out_d) || (swdio_oe != oe_d))) begin
            drive_glitch <= drive_glitch + 1;
        end
    end

    // Reference model: the bit stream an SWD host must emit and the response it must give.
    function automatic exp_t build_exp(input logic lrst, input logic apndp, input logic rnw,
                                       input logic [1:0] addr, input logic [31:0] wdata,
                                       input logic [2:0] tack, input logic [31:0] tdata,
                                       input logic tpar);
        exp_t e;
        int   k;
        int   hdr[8];
        logic ok;
        k     = 0;
        e.id  = 0;
        e.acc_cyc = 0;
        e.oe  = '0;
        e.out = '0;
        ok    = (tack == 3'b001);
        if (lrst) begin
            for (int i = 0; i < 56; i++) begin
                e.oe[k] = 1'b1; e.out[k] = 1'b1; k++;
            end
            e.ack = 3'b000; e.rdata = 32'd0; e.perr = 1'b0;
            e.n_bits = 56 + IDLE_CYC;
        end else begin
            hdr[0] = 1;
            hdr[1] = int'(apndp);
            hdr[2] = int'(rnw);
            hdr[3] = int'(addr[0]);
            hdr[4] = int'(addr[1]);
            hdr[5] = (hdr[1] + hdr[2] + hdr[3] + hdr[4]) % 2;
            hdr[6] = 0;
            hdr[7] = 1;
            for (int i = 0; i < 8; i++) begin
                e.oe[k] = 1'b1; e.out[k] = (hdr[i] != 0); k++;
            end
            k += 4;
            if (ok && rnw) begin
                k += 34;
            end else if (ok) begin
                k += 1;
                for (int i = 0; i < 32; i++) begin
                    e.oe[k] = 1'b1; e.out[k] = wdata[i]; k++;
                end
                e.oe[k] = 1'b1; e.out[k] = ($countones(wdata) % 2) != 0; k++;
            end else begin
                k += 1;
            end
            e.ack    = tack;
            e.rdata  = (ok && rnw) ? tdata : 32'd0;
            e.perr   = (ok && rnw) ? ((($countones(tdata) % 2) != 0) != tpar) : 1'b0;
            e.n_bits = ok ? 46 + IDLE_CYC : 13 + IDLE_CYC;
        end
        for (int i = 0; i < IDLE_CYC; i++) begin
            e.oe[k] = 1'b1; e.out[k] = 1'b0; k++;
        end
        return e;
    endfunction

    task automatic apply_stimulus(input logic lrst, input logic apndp, input logic rnw,
                                  input logic [1:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] tack, input logic [31:0] tdata,
                                  input logic tpar);
        exp_t e;
        int   waited;
        e = build_exp(lrst, apndp, rnw, addr, wdata, tack, tdata, tpar);
        op_id++;
        e.id = op_id;
        @(negedge fpga_clk);
        req_valid      = 1'b1;
        req_line_reset = lrst;
        req_apndp      = apndp;
        req_rnw        = rnw;
        req_addr       = addr;
        req_wdata      = wdata;
        waited = 0;
        while (!req_ready && waited < 3000) begin
            @(negedge fpga_clk);
            waited++;
        end
        if (!req_ready) begin
            check_output("req_ready timeout", 128'(req_ready), 128'(1));
            req_valid = 1'b0;
            return;
        end
        reply = {$urandom, $urandom, $urandom, $urandom};
        reply[11:9]  = tack;
        reply[43:12] = tdata;
        reply[44]    = tpar;
        @(posedge fpga_clk);
        #1;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        req_valid      = 1'b0;
        req_line_reset = ($urandom_range(1) != 0);
        req_apndp      = ($urandom_range(1) != 0);
        req_rnw        = ($urandom_range(1) != 0);
        req_addr       = 2'($urandom_range(3));
        req_wdata      = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " swclk"},     128'(swclk),     128'(0));
        check_output({tag, " swdio_oe"},  128'(swdio_oe),  128'(1));
        check_output({tag, " swdio_out"}, 128'(swdio_out), 128'(0));
        check_output({tag, " req_ready"}, 128'(req_ready), 128'(1));
        check_output({tag, " rsp_valid"}, 128'(rsp_valid), 128'(0));
        check_output({tag, " rsp_ack"},   128'(rsp_ack),   128'(0));
        check_output({tag, " rsp_rdata"}, 128'(rsp_rdata), 128'(0));
        check_output({tag, " rsp_perr"},  128'(rsp_perr),  128'(0));
    endtask

    // Scoreboard monitor: every response strobe is matched against the oldest expectation.
    initial begin
        exp_t         e;
        logic [127:0] mask;
        forever begin
            @(negedge fpga_clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected rsp_valid", 128'(rsp_valid), 128'(0));
                end else begin
                    e    = exp_q.pop_front();
                    mask = (128'(1) << e.n_bits) - 128'(1);
                    $display("[TB] response for op %0d", e.id);
                    check_output("latency",     128'(cyc - e.acc_cyc), 128'(e.n_bits * BIT_CYC));
                    check_output("rsp_ack",     128'(rsp_ack),   128'(e.ack));
                    check_output("rsp_rdata",   128'(rsp_rdata), 128'(e.rdata));
                    check_output("rsp_perr",    128'(rsp_perr),  128'(e.perr));
                    check_output("swclk pulses", 128'(tgt_bit),  128'(e.n_bits));
                    check_output("oe stream",   cap_oe & mask,   e.oe & mask);
                    check_output("out stream",  cap_out & e.oe & mask, e.out & e.oe & mask);
                end
                @(negedge fpga_clk);
                check_output("rsp_valid width", 128'(rsp_valid), 128'(0));
            end
        end
    end

    logic [2:0] ack_pick [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b111, 3'b000};

    initial begin
        int waited;
        logic [31:0] d;
        fpga_rst = 1'b0;
        repeat (3) @(posedge fpga_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge fpga_clk);
        fpga_rst = 1'b1;

        apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 3'b001, 32'h0BB11477, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'b01, 32'h20000000, 3'b001, 32'h12345678, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,        3'b010, 32'hFFFFFFFF, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0,        3'b001, 32'h00000001, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 2'b11, 32'hA5A5A5A5, 3'b001, 32'h55555555, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D, 3'b100, 32'h0,        1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'b11, 32'h0,        3'b111, 32'hFFFFFFFF, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'b01, 32'h0,        3'b000, 32'h0,        1'b0);

        // Abort a write at bit 20 with reset; no response may follow.
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'hFFFF0000, 3'b001, 32'h0, 1'b0);
        waited = 0;
        while (tgt_bit < 20 && waited < 2000) begin
            @(negedge fpga_clk);
            waited++;
        end
        check_output("bit 20 reached", 128'(tgt_bit >= 20), 128'(1));
        @(negedge fpga_clk);
        fpga_rst = 1'b0;
        @(posedge fpga_clk);
        #1;
        check_reset_outputs("abort");
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
        end
        @(negedge fpga_clk);
        fpga_rst = 1'b1;
        repeat (600) @(negedge fpga_clk);
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 32'h0BB11477, 1'b1);

        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            apply_stimulus($urandom_range(7) == 0, $urandom_range(1) != 0, $urandom_range(1) != 0,
                           2'($urandom_range(3)), $urandom, ack_pick[$urandom_range(7)], d,
                           $urandom_range(1) != 0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 3000) begin
            @(negedge fpga_clk);
            waited++;
        end
        check_output("all responses seen", 128'(exp_q.size()), 128'(0));
        check_output("drive stable while swclk high", 128'(drive_glitch), 128'(0));
        repeat (4) @(negedge fpga_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/swd_host.md
SWD_HOST -- requirements
Module: swd_host

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, giving the fpga_clk cycles per swclk half-period (legal range 1..255).
REQ-002 The module SHALL have parameter IDLE_CYC, default 2, giving the number of idle (swdio low) bit periods appended after every operation.
REQ-003 fpga_clk  input  1  single system clock.
REQ-004 fpga_rst  input  1  reset, synchronous to fpga_clk, active-low.
REQ-005 req_valid  input  1  operation request.
REQ-006 req_ready  output  1  request can be accepted.
REQ-007 req_line_reset  input  1  perform a line reset instead of a transfer.
REQ-008 req_apndp  input  1  1 = AP access, 0 = DP access.
REQ-009 req_rnw  input  1  1 = read, 0 = write.
REQ-010 req_addr  input  2  register address A[3:2].
REQ-011 req_wdata  input  32  write data.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_ack  output  3  ACK as received (OK=001, WAIT=010, FAULT=100); 000 for a line reset.
REQ-014 rsp_rdata  output  32  read data.
REQ-015 rsp_perr  output  1  read-data parity mismatch.
REQ-016 swclk  output  1  drives SWCLKTCK.
REQ-017 swdio_out  output  1  drive value for SWDIOTMS.
REQ-018 swdio_oe  output  1  1 = host drives SWDIOTMS.
REQ-019 swdio_in  input  1  sampled SWDIOTMS.

Function
REQ-020 The bit period SHALL be 2*CLK_DIV fpga_clk cycles: swclk low for the first CLK_DIV cycles and high for the second CLK_DIV cycles. swclk SHALL stay low while IDLE.
REQ-021 swdio_out and swdio_oe SHALL change only on the fpga_clk edge that starts a bit (swclk falling or held low).
REQ-022 swdio_in SHALL be sampled on the last fpga_clk cycle of the low phase, immediately before swclk rises.
REQ-023 The module SHALL use these states: IDLE, LRST, REQ, TRN1, ACK, RDATA, TRN2, WDATA, IDLE_BITS.
REQ-024 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready, and all req_* inputs SHALL be registered on acceptance.
REQ-025 LRST: swdio_oe=1 and swdio_out=1 for 56 bits, then IDLE_BITS.
REQ-026 REQ: 8 bits driven LSB first: start=1, APnDP, RnW, A2, A3, parity = XOR(APnDP, RnW, A2, A3), stop=0, park=1.
REQ-027 TRN1 (1 bit, swdio_oe=0) SHALL be followed by ACK (3 bits, swdio_oe=0, LSB received first).
REQ-028 When ACK=001 and RnW=1: RDATA (32 data bits LSB first plus a parity bit, swdio_oe=0), then TRN2 (1 bit, swdio_oe=0), then IDLE_BITS.
REQ-029 When ACK=001 and RnW=0: TRN2 (1 bit, swdio_oe=0), then WDATA (32 bits LSB first plus XOR-reduction parity, swdio_oe=1), then IDLE_BITS.
REQ-030 For any ACK other than 001 (including 111 or 000, meaning no target): TRN2, then IDLE_BITS. There SHALL be no data phase, and rsp_rdata SHALL be 0.
REQ-031 IDLE_BITS: swdio_oe=1 and swdio_out=0 for IDLE_CYC bits, then IDLE.
REQ-032 rsp_valid SHALL pulse for exactly 1 cycle on entry to IDLE. rsp_* SHALL hold their values until the next rsp_valid.
REQ-033 rsp_perr SHALL be (XOR of the 32 received data bits) != received parity bit, for OK reads only; it SHALL be 0 otherwise.
REQ-034 Latency from the acceptance cycle to rsp_valid SHALL be N*2*CLK_DIV cycles, where N = 46+IDLE_CYC for an OK transfer, 13+IDLE_CYC for a non-OK transfer, and 56+IDLE_CYC for a line reset.
REQ-035 req_valid deasserted mid-operation SHALL have no effect on the operation in progress. A request presented during an operation SHALL wait until req_ready=1.
REQ-036 req_line_reset=1 SHALL take priority over all other req_* fields.

Reset
REQ-037 When fpga_rst=0 at a fpga_clk edge, on that edge: state=IDLE, swclk=0, swdio_oe=1, swdio_out=0, req_ready=1, rsp_valid=0, rsp_ack=000, rsp_rdata=0, rsp_perr=0, bit and divider counters=0.
REQ-038 A reset mid-operation SHALL abort the operation without a response; the first operation after reset SHALL be a normal operation.

Verification
REQ-039 DP read, A=00 (IDCODE), CLK_DIV=4, IDLE_CYC=2; target model returns ACK 001, data 0x0BB11477, parity 1 -> request bits 1,0,1,0,0,1,0,1; rsp_ack=001; rsp_rdata=0x0BB11477; rsp_perr=0; rsp_valid 384 cycles after acceptance.
REQ-040 AP write, A=01, wdata 0x20000000, ACK 001 -> request bits 1,1,0,1,0,0,0,1; data bits: bit29=1, others 0, parity=1; swdio_oe=0 only during TRN1, ACK and TRN2.
REQ-041 DP read, target returns ACK 010 (WAIT) -> rsp_ack=010; rsp_rdata=0; no data phase; rsp_valid after 15 bits (120 cycles).
REQ-042 DP read, data 0x00000001 with parity 0 -> rsp_perr=1; rsp_rdata=0x00000001.
REQ-043 Line reset -> 56 swclk pulses with swdio_out=1, then 2 low bits; rsp_ack=000; rsp_valid at cycle 464.
REQ-044 Assert fpga_rst=0 at bit 20 of a write -> next cycle swclk=0, swdio_oe=1, swdio_out=0, req_ready=1; no rsp_valid; a following DP read completes normally.
